// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter:
// function codes, result groups, expected flags, FSM states.
package alu_pkg;

  localparam logic [3:0] FUN_ADD  = 4'b0000;
  localparam logic [3:0] FUN_SUB  = 4'b0001;
  localparam logic [3:0] FUN_AND  = 4'b0100;
  localparam logic [3:0] FUN_OR   = 4'b0101;
  localparam logic [3:0] FUN_XOR  = 4'b0110;
  localparam logic [3:0] FUN_NOT  = 4'b0111;
  localparam logic [3:0] FUN_EQ   = 4'b1000;
  localparam logic [3:0] FUN_LT   = 4'b1001;
  localparam logic [3:0] FUN_CMP  = 4'b1010;
  localparam logic [3:0] FUN_SHR1 = 4'b1100;
  localparam logic [3:0] FUN_SHL1 = 4'b1101;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  localparam logic [3:0] FLG_ARITH = 4'b1000;
  localparam logic [3:0] FLG_LOGIC = 4'b0100;
  localparam logic [3:0] FLG_CMP   = 4'b0010;
  localparam logic [3:0] FLG_SHIFT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CAPT,
    ST_RESP
  } state_t;

  function automatic logic [3:0] grp_flag(
    input logic [1:0] grp
  );
    logic [3:0] f;
    f = FLG_ARITH;
    unique case (grp)
      GRP_ARITH: f = FLG_ARITH;
      GRP_LOGIC: f = FLG_LOGIC;
      GRP_CMP:   f = FLG_CMP;
      GRP_SHIFT: f = FLG_SHIFT;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_gnt remembers the
// previous winner so the other requester wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       win,
  output logic       last_gnt
);

  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_gnt;
      default: win = 1'b0;
    endcase
  end

  assign gnt = (|req) ? (win ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst)
      last_gnt <= 1'b1;
    else if (en)
      last_gnt <= win;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters,
// one operation in flight, response held until taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         REQ_VALID,
  output logic [1:0]         REQ_READY,
  input  logic [2*WIDTH-1:0] REQ_A,
  input  logic [2*WIDTH-1:0] REQ_B,
  input  logic [7:0]         REQ_FUN,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  output logic [3:0]         ALU_FUN,
  input  logic [WIDTH-1:0]   ALU_ARITH_OUT,
  input  logic [WIDTH-1:0]   ALU_LOGIC_OUT,
  input  logic [WIDTH-1:0]   ALU_CMP_OUT,
  input  logic [WIDTH-1:0]   ALU_SHIFT_OUT,
  input  logic               ALU_CARRY,
  input  logic [3:0]         ALU_FLAGS,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [WIDTH-1:0]   RSP_DATA,
  output logic               RSP_CARRY,
  output logic               RSP_ERR,
  output logic               BUSY,
  output logic [7:0]         DONE_CNT
);

  state_t st;
  state_t st_n;

  logic [1:0]       gnt;
  logic             win;
  logic             last_gnt;
  logic             accept;
  logic             rsp_fire;
  logic             id_q;
  logic [1:0]       grp;
  logic [WIDTH-1:0] sel_data;

  assign accept = (st == ST_IDLE) && (|REQ_VALID) && !RST;
  assign rsp_fire = (st == ST_RESP) && RSP_READY;

  rr_arb2 u_arb (
    .clk      (CLK),
    .rst      (RST),
    .req      (REQ_VALID),
    .en       (accept),
    .gnt      (gnt),
    .win      (win),
    .last_gnt (last_gnt)
  );

  assign REQ_READY = accept ? gnt : 2'b00;
  assign RSP_VALID = (st == ST_RESP);
  assign BUSY      = (st != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST)
      st <= ST_IDLE;
    else
      st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      ST_IDLE: if (|REQ_VALID) st_n = ST_EXEC;
      ST_EXEC: st_n = ST_CAPT;
      ST_CAPT: st_n = ST_RESP;
      ST_RESP: if (RSP_READY) st_n = ST_IDLE;
    endcase
  end

  assign grp = ALU_FUN[3:2];

  always_comb begin
    sel_data = ALU_ARITH_OUT;
    unique case (grp)
      GRP_ARITH: sel_data = ALU_ARITH_OUT;
      GRP_LOGIC: sel_data = ALU_LOGIC_OUT;
      GRP_CMP:   sel_data = ALU_CMP_OUT;
      GRP_SHIFT: sel_data = ALU_SHIFT_OUT;
    endcase
  end

  // ALU_* only change on accept, so they hold through RESP/IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      id_q      <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
      RSP_CARRY <= 1'b0;
      RSP_ERR   <= 1'b0;
      DONE_CNT  <= '0;
    end else begin
      if (accept) begin
        ALU_A   <= win ? REQ_A[2*WIDTH-1:WIDTH]
                       : REQ_A[WIDTH-1:0];
        ALU_B   <= win ? REQ_B[2*WIDTH-1:WIDTH]
                       : REQ_B[WIDTH-1:0];
        ALU_FUN <= win ? REQ_FUN[7:4] : REQ_FUN[3:0];
        id_q    <= win;
      end
      if (st == ST_CAPT) begin
        RSP_ID    <= id_q;
        RSP_DATA  <= sel_data;
        RSP_CARRY <= (grp == GRP_ARITH) ? ALU_CARRY : 1'b0;
        RSP_ERR   <= (ALU_FLAGS != grp_flag(grp));
      end
      if (rsp_fire)
        DONE_CNT <= DONE_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered ALU stub;
// table of single operations plus backpressure and reset runs.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [7:0]     req_fun;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [3:0]     alu_fun;
  logic [W-1:0]   arith_out;
  logic [W-1:0]   logic_out;
  logic [W-1:0]   cmp_out;
  logic [W-1:0]   shift_out;
  logic           alu_carry;
  logic [3:0]     alu_flags;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_carry;
  logic           rsp_err;
  logic           busy;
  logic [7:0]     done_cnt;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .CLK           (clk),
    .RST           (rst),
    .REQ_VALID     (req_valid),
    .REQ_READY     (req_ready),
    .REQ_A         (req_a),
    .REQ_B         (req_b),
    .REQ_FUN       (req_fun),
    .ALU_A         (alu_a),
    .ALU_B         (alu_b),
    .ALU_FUN       (alu_fun),
    .ALU_ARITH_OUT (arith_out),
    .ALU_LOGIC_OUT (logic_out),
    .ALU_CMP_OUT   (cmp_out),
    .ALU_SHIFT_OUT (shift_out),
    .ALU_CARRY     (alu_carry),
    .ALU_FLAGS     (alu_flags),
    .RSP_VALID     (rsp_valid),
    .RSP_READY     (rsp_ready),
    .RSP_ID        (rsp_id),
    .RSP_DATA      (rsp_data),
    .RSP_CARRY     (rsp_carry),
    .RSP_ERR       (rsp_err),
    .BUSY          (busy),
    .DONE_CNT      (done_cnt)
  );

  // Registered ALU stub; carry is the add carry for every
  // non-SUB code so the arbiter's carry masking is visible.
  logic [W:0] sum17;
  logic [W:0] dif17;
  assign sum17 = {1'b0, alu_a} + {1'b0, alu_b};
  assign dif17 = {1'b0, alu_a} - {1'b0, alu_b};

  always_ff @(posedge clk) begin
    arith_out <= (alu_fun == FUN_SUB) ? dif17[W-1:0]
                                      : sum17[W-1:0];
    alu_carry <= (alu_fun == FUN_SUB) ? dif17[W] : sum17[W];
    case (alu_fun[1:0])
      2'b00:   logic_out <= alu_a & alu_b;
      2'b01:   logic_out <= alu_a | alu_b;
      2'b10:   logic_out <= alu_a ^ alu_b;
      default: logic_out <= ~alu_a;
    endcase
    case (alu_fun)
      FUN_EQ:  cmp_out <= W'(alu_a == alu_b);
      FUN_LT:  cmp_out <= W'(alu_a < alu_b);
      FUN_CMP: cmp_out <= (alu_a == alu_b) ? W'(0) :
                          (alu_a < alu_b) ? W'(1) : W'(2);
      default: cmp_out <= '0;
    endcase
    case (alu_fun)
      FUN_SHR1: shift_out <= alu_a >> 1;
      FUN_SHL1: shift_out <= alu_a << 1;
      default:  shift_out <= alu_a << alu_b[3:0];
    endcase
    if (alu_fun == FUN_SUB)
      alu_flags <= 4'b0000;
    else
      alu_flags <= grp_flag(alu_fun[3:2]);
  end

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [3:0]   f0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [3:0]   f1;
    logic         id;
    logic [W-1:0] data;
    logic         carry;
    logic         err;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after an edge with the DUT idle.
  task automatic run_op(input vec_t v, input string tag);
    logic [1:0]   exp_rdy;
    logic [W-1:0] exp_a;
    exp_rdy = v.id ? 2'b10 : 2'b01;
    exp_a   = v.id ? v.a1 : v.a0;
    req_valid = v.valid;
    req_a     = {v.a1, v.a0};
    req_b     = {v.b1, v.b0};
    req_fun   = {v.f1, v.f0};
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_ready_c0"}, 32'(req_ready), 32'(exp_rdy));
    tick();
    chk({tag, "_busy_c1"}, 32'(busy), 1);
    chk({tag, "_ready_c1"}, 32'(req_ready), 0);
    tick();
    chk({tag, "_valid_c2"}, 32'(rsp_valid), 0);
    chk({tag, "_ready_c2"}, 32'(req_ready), 0);
    tick();
    chk({tag, "_valid_c3"}, 32'(rsp_valid), 1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(v.id));
    chk({tag, "_data"}, 32'(rsp_data), 32'(v.data));
    chk({tag, "_carry"}, 32'(rsp_carry), 32'(v.carry));
    chk({tag, "_err"}, 32'(rsp_err), 32'(v.err));
    chk({tag, "_alu_a_hold"}, 32'(alu_a), 32'(exp_a));
    req_valid = 2'b00;
    tick();
    exp_done++;
    chk({tag, "_busy_idle"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    tbl[0] = '{2'b11, 16'd32780, 16'd32770, FUN_ADD,
               16'd9, 16'd3, FUN_AND, 1'b0, 16'd14, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 16'd32780, 16'd32770, FUN_ADD,
               16'd9, 16'd3, FUN_AND, 1'b1, 16'd1, 1'b0, 1'b0};
    tbl[2] = '{2'b11, 16'd32780, 16'd32770, FUN_ADD,
               16'd9, 16'd3, FUN_AND, 1'b0, 16'd14, 1'b1, 1'b0};
    tbl[3] = '{2'b01, 16'd10, 16'd5, FUN_ADD,
               16'd0, 16'd0, FUN_ADD, 1'b0, 16'd15, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 16'd0, 16'd0, FUN_ADD,
               16'd9, 16'd3, FUN_SHL1, 1'b1, 16'd18, 1'b0, 1'b0};
    tbl[5] = '{2'b01, 16'd9, 16'd3, FUN_EQ,
               16'd0, 16'd0, FUN_ADD, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[6] = '{2'b01, 16'd7, 16'd2, FUN_SUB,
               16'd0, 16'd0, FUN_ADD, 1'b0, 16'd5, 1'b0, 1'b1};
    tbl[7] = '{2'b01, 16'h80F0, 16'h8F00, FUN_OR,
               16'd0, 16'd0, FUN_ADD, 1'b0, 16'h8FF0, 1'b0, 1'b0};
    tbl[8] = '{2'b10, 16'd0, 16'd0, FUN_ADD,
               16'd10, 16'd5, FUN_CMP, 1'b1, 16'd2, 1'b0, 1'b0};

    rst = 1'b1;
    req_valid = 2'b00;
    req_a = '0;
    req_b = '0;
    req_fun = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_done", 32'(done_cnt), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_fun", 32'(alu_fun), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i], $sformatf("v%0d", i));

    // Backpressure: response held, new request held off.
    v = '{2'b01, 16'd10, 16'd5, FUN_CMP,
          16'd0, 16'd0, FUN_ADD, 1'b0, 16'd2, 1'b0, 1'b0};
    req_valid = v.valid;
    req_a = {v.a1, v.a0};
    req_b = {v.b1, v.b0};
    req_fun = {v.f1, v.f0};
    rsp_ready = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("bp%0d_data", i), 32'(rsp_data), 2);
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 0);
      chk($sformatf("bp%0d_done", i), 32'(done_cnt),
          32'(exp_done));
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    tick();
    exp_done++;
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_valid", 32'(rsp_valid), 0);
    chk("bp_done", 32'(done_cnt), 32'(exp_done));

    // Reset in CAPT discards the op and restores tie order.
    req_valid = 2'b11;
    req_a = {16'd9, 16'd10};
    req_b = {16'd3, 16'd5};
    req_fun = {FUN_AND, FUN_ADD};
    tick();
    tick();
    chk("mid_busy_capt", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_done", 32'(done_cnt), 0);
    chk("mid_rst_alu_a", 32'(alu_a), 0);
    chk("mid_rst_data", 32'(rsp_data), 0);
    tick();
    chk("mid_rst_hold_busy", 32'(busy), 0);
    chk("mid_rst_hold_valid", 32'(rsp_valid), 0);
    rst = 1'b0;
    exp_done = 0;
    run_op(tbl[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
